fb_buff_reader: RTL

Frame-buffer reader downstream of the HPS-driven 8-bit "buffer full" PIO. On a rising edge of the PIO's start bit, it burst-reads one frame from DDR through an Avalon-MM read master. Data is buffered in an internal FIFO and emitted as a 32-bit valid/ready stream to the video/packet sink. It raises `done` for software to poll through an input PIO.

---
 rtl/fb_buff_reader_if.sv | 30 +++
 rtl/fb_buff_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fb_buff_reader_if.sv
// Bundle of the Avalon-MM burst read master and the 32-bit valid/ready stream of fb_buff_reader.
// master: the reader's view; slave: the DDR port / sink side.
interface fb_buff_reader_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [4:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        src_sop;
    logic        src_eop;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output src_data, src_valid, src_sop, src_eop,
        input  src_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  src_data, src_valid, src_sop, src_eop,
        output src_ready
    );
endinterface

// File: rtl/fb_buff_reader.sv
// Frame-buffer reader: on a PIO start edge, burst-reads one frame from DDR into a show-ahead FIFO
// and streams it out. Define FB_BUFF_READER_SOP_EOP_EN to generate src_sop/src_eop framing.
module fb_buff_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] BUF_STRIDE  = 32'h0010_0000,
    parameter int unsigned FRAME_WORDS = 4096,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FIFO_DEPTH  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       full_buff_i,
    fb_buff_reader_if.master bus_io,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned OutW      = $clog2(FRAME_WORDS);
    localparam int unsigned NumBursts = FRAME_WORDS / BURST_LEN;
    localparam int unsigned BurstW    = $clog2(NumBursts + 1);

    localparam logic [31:0]       BurstBytes = 32'(BURST_LEN * 4);
    localparam logic [CntW-1:0]   BurstCnt   = CntW'(BURST_LEN);
    localparam logic [OutW-1:0]   LastWord   = OutW'(FRAME_WORDS - 1);
    localparam logic [BurstW-1:0] LastBurst  = BurstW'(NumBursts - 1);

    typedef enum logic [2:0] {StIdle, StReq, StSpace, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic [31:0]         addr_q, addr_d;
    logic                read_q, read_d;
    logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
    logic                done_q, done_d;
    logic [CntW-1:0]     outst_q, outst_d;
    logic [OutW-1:0]     out_cnt_q, out_cnt_d;

    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;

    logic                start, accept, fifo_wr, fifo_empty, fifo_full, pop, last_pop, space_ok;
    logic                unused_pio;

    assign unused_pio = ^full_buff_i[7:3];

    assign start      = full_buff_i[0] & ~start_q & (state_q == StIdle);
    assign accept     = read_q & ~bus_io.avm_waitrequest;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CntW'(FIFO_DEPTH));
    // Late read data from an aborted frame is discarded while idle.
    assign fifo_wr    = bus_io.avm_readdatavalid & (state_q != StIdle);
    assign pop        = ~fifo_empty & bus_io.src_ready;
    assign last_pop   = pop & (out_cnt_q == LastWord);
    // Words already committed (buffered + in flight) must leave room for a whole burst.
    assign space_ok   = ({1'b0, fifo_cnt_q} + {1'b0, outst_q} + (CntW + 1)'(BURST_LEN))
                        <= (CntW + 1)'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        read_d      = read_q;
        burst_cnt_d = burst_cnt_q;
        done_d      = done_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StReq;
                    read_d      = 1'b1;
                    done_d      = 1'b0;
                    burst_cnt_d = '0;
                    addr_d      = BASE_ADDR + {30'd0, full_buff_i[2:1]} * BUF_STRIDE;
                end
            end
            StReq: begin
                if (accept) begin
                    read_d      = 1'b0;
                    addr_d      = addr_q + BurstBytes;
                    burst_cnt_d = burst_cnt_q + BurstW'(1);
                    state_d     = (burst_cnt_q == LastBurst) ? StDrain : StSpace;
                end
            end
            StSpace: begin
                if (space_ok) begin
                    state_d = StReq;
                    read_d  = 1'b1;
                end
            end
            StDrain: begin
                if (last_pop) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outst_d    = outst_q + (accept ? BurstCnt : '0) - CntW'(fifo_wr);
        fifo_cnt_d = fifo_cnt_q + CntW'(fifo_wr) - CntW'(pop);
        wr_ptr_d   = fifo_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        out_cnt_d  = out_cnt_q;
        if (pop) begin
            out_cnt_d = (out_cnt_q == LastWord) ? '0 : out_cnt_q + OutW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            addr_q      <= BASE_ADDR;
            read_q      <= 1'b0;
            burst_cnt_q <= '0;
            done_q      <= 1'b0;
            outst_q     <= '0;
            out_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= full_buff_i[0];
            addr_q      <= addr_d;
            read_q      <= read_d;
            burst_cnt_q <= burst_cnt_d;
            done_q      <= done_d;
            outst_q     <= outst_d;
            out_cnt_q   <= out_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= bus_io.avm_readdata;
        end
    end

    // Burst issue is throttled so this can only fire on a design bug.
    assert property (@(posedge clk) disable iff (!reset_n) !(fifo_wr && fifo_full))
        else $error("fb_buff_reader: write into full FIFO");

    assign bus_io.avm_address    = addr_q;
    assign bus_io.avm_read       = read_q;
    assign bus_io.avm_burstcount = 5'(BURST_LEN);
    assign bus_io.src_data       = mem_q[rd_ptr_q];
    assign bus_io.src_valid      = ~fifo_empty;
    assign busy_o                = (state_q != StIdle);
    assign done_o                = done_q;

`ifdef FB_BUFF_READER_SOP_EOP_EN
    assign bus_io.src_sop = ~fifo_empty & (out_cnt_q == '0);
    assign bus_io.src_eop = ~fifo_empty & (out_cnt_q == LastWord);
`else
    assign bus_io.src_sop = 1'b0;
    assign bus_io.src_eop = 1'b0;
`endif
endmodule
